// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter via a launch/handshake FSM; overflow/drop_count live only under UART_TX_FIFO_DROP_STATS_EN.
// Write-to-launch is 2 cycles when idle; writes arriving while full are dropped (no backpressure toward the writer).
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [PAYLOAD_BITS-1:0]   wr_data,
  input  logic                      flush,
  input  logic                      uart_tx_busy,
  output logic                      uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]   uart_tx_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [7:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic [1:0]              wait_cnt_q, wait_cnt_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic                    push;
  logic                    pop;

  // Fullness is judged on the registered flag, so a same-cycle pop never rescues a write.
  always_comb begin
    push = wr_valid && !full_q && !flush;
    pop  = (state_q == LAUNCH) && !empty_q && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // The head byte is captured on entry to LAUNCH and held until the next launch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (!empty_q && !uart_tx_busy) begin
          state_d   = LAUNCH;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      LAUNCH: begin
        state_d    = WAIT_BUSY;
        wait_cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy)             state_d = WAIT_DONE;
        else if (wait_cnt_q == 2'd3)  state_d = IDLE;
        else                          wait_cnt_d = wait_cnt_q + 2'd1;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_en = (state_q == LAUNCH);
  end

  assign uart_tx_data = tx_data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign level        = level_q;

`ifdef UART_TX_FIFO_DROP_STATS_EN
  logic       overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       drop;

  always_comb begin
    drop         = wr_valid && full_q && !flush;
    overflow_d   = drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`else
  assign overflow   = 1'b0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a transmitter busy model plus per-scenario tasks with hand-computed expectations.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_DROP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int EXP_OV = STATS ? 4 : 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       uart_tx_busy = 1'b0;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;
  int en_count = 0;
  logic [7:0] sent[$];

  bit busy_force = 1'b0;
  bit model_en = 1'b0;
  bit pending = 1'b0;
  int model_hold = 10;
  int busy_left = 0;

  uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .flush(flush),
    .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Launch monitor and transmitter model: busy rises the cycle after a launch and stays up model_hold cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (uart_tx_en) begin
        en_count++;
        sent.push_back(uart_tx_data);
      end
      if (busy_force) begin
        uart_tx_busy = 1'b1;
      end else if (!model_en) begin
        uart_tx_busy = 1'b0;
        busy_left = 0;
        pending = 1'b0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          busy_left = model_hold;
        end
        if (busy_left > 0) begin
          uart_tx_busy = 1'b1;
          busy_left--;
        end else begin
          uart_tx_busy = 1'b0;
        end
        if (uart_tx_en) pending = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic do_reset();
    busy_force = 1'b0;
    model_en = 1'b0;
    wr_valid = 1'b0;
    flush = 1'b0;
    wr_data = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    en_count = 0;
    sent.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %0b want 0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h want 00", uart_tx_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags: got empty=%0b full=%0b want 1/0", empty, full); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL rst_stats: got ov=%0b dc=%0d want 0/0", overflow, drop_count); end
    do_reset();
    checks++; if (uart_tx_en !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL rst_release: got en=%0b level=%0d empty=%0b want 0/0/1", uart_tx_en, level, empty); end
  endtask

  task automatic test_single();
    do_reset();
    model_en = 1'b1;
    model_hold = 10;
    wr_data = 8'h41;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early: got %0b want 0", uart_tx_en); end
    @(negedge clk);
    checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL single_en_n2: got %0b want 1", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %0h want 41", uart_tx_data); end
    repeat (20) @(negedge clk);
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_level: got level=%0d empty=%0b want 0/1", level, empty); end
    checks++; if (en_count !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", en_count); end
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL single_hold: got %0h want 41", uart_tx_data); end
  endtask

  task automatic test_overflow_burst();
    int ov;
    int bad;
    do_reset();
    busy_force = 1'b1;
    model_en = 1'b1;
    model_hold = 3;
    ov = 0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      if (overflow === 1'b1) ov++;
    end
    wr_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (overflow === 1'b1) ov++;
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL burst_level: got %0d want 16", level); end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL burst_flags: got full=%0b empty=%0b want 1/0", full, empty); end
    checks++; if (ov !== EXP_OV) begin errors++; $display("FAIL burst_ov_pulses: got %0d want %0d", ov, EXP_OV); end
    checks++; if (drop_count !== 8'(EXP_OV)) begin errors++; $display("FAIL burst_drop_count: got %0d want %0d", drop_count, EXP_OV); end
    checks++; if (en_count !== 0) begin errors++; $display("FAIL burst_no_launch: got %0d want 0", en_count); end
    busy_force = 1'b0;
    for (int t = 0; t < 400 && en_count < 16; t++) @(negedge clk);
    checks++; if (en_count < 16) begin errors++; $display("FAIL burst_drain_timeout: got %0d launches want 16", en_count); end
    repeat (20) @(negedge clk);
    checks++; if (en_count !== 16) begin errors++; $display("FAIL burst_total: got %0d want 16", en_count); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (k >= sent.size()) bad++;
      else if (sent[k] !== 8'(k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL burst_order: got %0d misordered bytes want 0", bad); end
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL burst_drained: got level=%0d empty=%0b full=%0b want 0/1/0", level, empty, full); end
  endtask

  task automatic test_write_pop_same_cycle();
    do_reset();
    busy_force = 1'b1;
    model_en = 1'b1;
    model_hold = 3;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL wp_pre_level: got %0d want 5", level); end
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h10) begin
      errors++; $display("FAIL wp_launch: got en=%0b data=%0h want 1/10", uart_tx_en, uart_tx_data); end
    wr_valid = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL wp_level: got %0d want 5", level); end
  endtask

  task automatic test_flush();
    do_reset();
    model_en = 1'b1;
    model_hold = 10;
    wr_valid = 1'b1; wr_data = 8'hAA;
    @(negedge clk); wr_data = 8'hBB;
    @(negedge clk); wr_data = 8'hCC;
    @(negedge clk); wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (level !== 5'd2 || uart_tx_busy !== 1'b1) begin
      errors++; $display("FAIL flush_pre: got level=%0d busy=%0b want 2/1", level, uart_tx_busy); end
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hDD;
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level: got level=%0d empty=%0b want 0/1", level, empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_no_ov: got %0b want 0", overflow); end
    repeat (40) @(negedge clk);
    checks++; if (en_count !== 1) begin errors++; $display("FAIL flush_launches: got %0d want 1", en_count); end
    checks++; if (sent.size() < 1 || sent[0] !== 8'hAA) begin errors++; $display("FAIL flush_first_byte: got %0d launches want AA launched", sent.size()); end
    checks++; if (uart_tx_data !== 8'hAA || level !== 5'd0) begin
      errors++; $display("FAIL flush_after: got data=%0h level=%0d want AA/0", uart_tx_data, level); end
  endtask

  task automatic test_busy_timeout();
    bit exp;
    do_reset();
    wr_valid = 1'b1;
    wr_data = 8'h11;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) wr_data = 8'h22;
      if (k == 2) wr_valid = 1'b0;
      exp = (k == 2 || k == 8);
      checks++; if (uart_tx_en !== exp) begin errors++; $display("FAIL timeout_en_k%0d: got %0b want %0b", k, uart_tx_en, exp); end
      if (exp) begin
        checks++; if (uart_tx_data !== ((k == 2) ? 8'h11 : 8'h22)) begin
          errors++; $display("FAIL timeout_data_k%0d: got %0h want %0h", k, uart_tx_data, (k == 2) ? 8'h11 : 8'h22); end
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int cnt_at_reset;
    do_reset();
    model_en = 1'b1;
    model_hold = 10;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd7 || uart_tx_busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got level=%0d busy=%0b want 7/1", level, uart_tx_busy); end
    cnt_at_reset = en_count;
    reset = 1'b1;
    #1;
    checks++; if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00) begin
      errors++; $display("FAIL midrst_tx: got en=%0b data=%0h want 0/00", uart_tx_en, uart_tx_data); end
    checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL midrst_fifo: got level=%0d empty=%0b full=%0b want 0/1/0", level, empty, full); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL midrst_stats: got ov=%0b dc=%0d want 0/0", overflow, drop_count); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (en_count !== cnt_at_reset || level !== 5'd0) begin
      errors++; $display("FAIL midrst_after: got launches=%0d level=%0d want %0d/0", en_count - cnt_at_reset, level, 0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow_burst();
    test_write_pop_same_cycle();
    test_flush();
    test_busy_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 8, the byte width.
REQ-002 The block SHALL have parameter DEPTH, default 16, the FIFO entry count (power of two, 2..256).
REQ-003 The block SHALL have port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port wr_valid  input  1  write strobe; one byte per high cycle.
REQ-006 The block SHALL have port wr_data  input  PAYLOAD_BITS  byte to enqueue.
REQ-007 The block SHALL have port flush  input  1  synchronous FIFO clear.
REQ-008 The block SHALL have port uart_tx_busy  input  1  transmitter busy flag.
REQ-009 The block SHALL have port uart_tx_en  output  1  one-cycle launch pulse to transmitter.
REQ-010 The block SHALL have port uart_tx_data  output  PAYLOAD_BITS  byte being launched.
REQ-011 The block SHALL have ports full, empty  output  1 each  registered FIFO status.
REQ-012 The block SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-013 The block SHALL have port overflow  output  1  one-cycle pulse on a dropped write.
REQ-014 The block SHALL have port drop_count  output  8  saturating count of dropped writes.

Function
REQ-015 The block SHALL enqueue wr_data when wr_valid=1 and full=0, advancing the write pointer modulo DEPTH.
REQ-016 The block SHALL drop wr_valid when full=1 (judged on the registered level, even if a pop occurs the same cycle) and pulse overflow the next cycle.
REQ-017 The block SHALL run FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE->LAUNCH SHALL occur when empty=0 and uart_tx_busy=0; otherwise IDLE holds.
REQ-019 In LAUNCH the block SHALL drive uart_tx_en=1 for exactly one cycle, with uart_tx_data = head byte registered on entry; the head SHALL pop in this cycle; next state WAIT_BUSY.
REQ-020 WAIT_BUSY->WAIT_DONE SHALL occur on uart_tx_busy=1; after 4 cycles without busy the FSM SHALL return to IDLE (byte counted as sent).
REQ-021 WAIT_DONE->IDLE SHALL occur on uart_tx_busy=0.
REQ-022 Latency: wr_valid into an empty, idle FIFO at cycle N SHALL produce uart_tx_en=1 at cycle N+2.
REQ-023 uart_tx_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-024 Simultaneous write and pop SHALL leave level unchanged; level SHALL never exceed DEPTH nor go below 0.
REQ-025 flush=1 SHALL zero pointers and level next cycle, SHALL not abort a byte already launched, and SHALL take priority over a same-cycle write (write dropped, no overflow pulse).
REQ-026 drop_count SHALL saturate at 255 and clear only on reset.

Reset
REQ-027 On reset=1 the FSM SHALL enter IDLE immediately, with uart_tx_en=0, uart_tx_data=0, level=0, empty=1, full=0, overflow=0, drop_count=0.
REQ-028 Reset asserted mid-transfer SHALL discard all queued bytes; FIFO storage contents need not be cleared.

Configuration
REQ-029 With macro UART_TX_FIFO_DROP_STATS_EN defined, the block SHALL implement overflow and drop_count as specified.
REQ-030 Without UART_TX_FIFO_DROP_STATS_EN, overflow and drop_count SHALL be tied to 0 and their logic omitted; drop behaviour is otherwise unchanged.

Verification
REQ-031 Reset, write 0x41 once, busy model rises 1 cycle after en and holds 10 cycles -> uart_tx_en pulse 2 cycles after write, uart_tx_data=0x41, level back to 0.
REQ-032 Burst 20 writes 0x00..0x13 with busy held high -> level=16, full=1, 4 overflow pulses, drop_count=4; after releasing busy, bytes 0x00..0x0F emitted in order.
REQ-033 Write and pop in the same cycle at level=5 -> level stays 5.
REQ-034 Write 3 bytes, assert flush during the first byte's WAIT_DONE -> level=0, no further uart_tx_en, first byte completes.
REQ-035 Busy never rises after LAUNCH -> FSM returns to IDLE after 4 cycles and launches the next byte.
REQ-036 Assert reset with level=7 mid-WAIT_DONE -> outputs at reset values immediately, no uart_tx_en after release.
